seg_decode_rx: RTL and testbench

SEG_DECODE_RX -- requirements
Module: seg_decode_rx

---
 rtl/seg_decode_rx.sv | 199 +++++++++++++++++++
 tb/tb_seg_decode_rx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_decode_rx.sv
// seg_decode_rx
// Receives a 7-segment pattern from an asynchronous source and turns it into
// a hex digit. The lines are synchronized first. A pattern is accepted only
// after it has stayed unchanged for STABLE_CYCLES consecutive samples. Each
// stable pattern is accepted exactly once.
//
// Parameters
//   STABLE_CYCLES  consecutive identical samples required (1..255)
//   ERRW           width of err_cnt
//
// Ports
//   Clock      in   single clock, rising edge
//   Resetn     in   asynchronous active-low reset
//   seg[6:0]   in   active-low segments, bit0=a .. bit6=g, asynchronous
//   hex_ack    in   consumer acknowledge of hex_valid
//   hex[3:0]   out  digit of the last accepted valid pattern
//   hex_valid  out  new digit pending; held until acknowledged
//   blank      out  last accepted pattern was all segments off (7'h7F)
//   err        out  one-cycle pulse when an invalid pattern is accepted
//   overrun    out  sticky; a digit was accepted while one was still pending
//   err_cnt    out  saturating count of invalid accepted patterns
//
// Build option
//   SEG_DECODE_RX_ERRCNT_EN  when defined, err_cnt is a saturating counter;
//                            otherwise err_cnt is tied to zero and no counter
//                            flops exist.
module seg_decode_rx #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERRW          = 8
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic [6:0]      seg,
    input  logic            hex_ack,
    output logic [3:0]      hex,
    output logic            hex_valid,
    output logic            blank,
    output logic            err,
    output logic            overrun,
    output logic [ERRW-1:0] err_cnt
);

    typedef enum logic {SETTLE, STABLE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    logic [6:0] sync1_reg;
    logic [6:0] s_reg;
    logic [6:0] s_prev_reg;
    state_t     state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       accept;

    logic [3:0] digit;
    logic       code_valid;
    logic       code_blank;

    logic [3:0] hex_reg;
    logic       hex_valid_reg;
    logic       blank_reg;
    logic       err_reg;
    logic       overrun_reg;

    // Two-flop synchronizer. s_prev holds the previous synchronized sample
    // so that the settle logic can detect a change. It resets to the same
    // idle value as the synchronizer.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sync1_reg  <= 7'h7F;
            s_reg      <= 7'h7F;
            s_prev_reg <= 7'h7F;
        end else begin
            sync1_reg  <= seg;
            s_reg      <= sync1_reg;
            s_prev_reg <= s_reg;
        end
    end

    // Segment decode of the synchronized sample.
    always_comb begin
        digit      = 4'h0;
        code_valid = 1'b1;
        code_blank = 1'b0;
        case (s_reg)
            7'h40: digit = 4'h0;
            7'h79: digit = 4'h1;
            7'h24: digit = 4'h2;
            7'h30: digit = 4'h3;
            7'h19: digit = 4'h4;
            7'h12: digit = 4'h5;
            7'h02: digit = 4'h6;
            7'h78: digit = 4'h7;
            7'h00: digit = 4'h8;
            7'h18: digit = 4'h9;
            7'h08: digit = 4'hA;
            7'h03: digit = 4'hB;
            7'h46: digit = 4'hC;
            7'h21: digit = 4'hD;
            7'h06: digit = 4'hE;
            7'h0E: digit = 4'hF;
            7'h7F: begin
                code_valid = 1'b0;
                code_blank = 1'b1;
            end
            default: code_valid = 1'b0;
        endcase
    end

    // Settle FSM: state and stability counter.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_reg <= SETTLE;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // The counter holds its final value once the pattern is accepted. The
    // STABLE state blocks a second acceptance until s changes again.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        case (state_reg)
            SETTLE: begin
                if (s_reg != s_prev_reg) begin
                    cnt_next = 8'd0;
                end else if (cnt_reg == CNT_LAST) begin
                    accept     = 1'b1;
                    state_next = STABLE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            STABLE: begin
                if (s_reg != s_prev_reg) begin
                    state_next = SETTLE;
                    cnt_next   = 8'd0;
                end
            end
            default: begin
                state_next = SETTLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    // Output registers. A valid acceptance has priority over the
    // acknowledge, so a new digit arriving on the ack edge stays pending.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            hex_reg       <= 4'h0;
            hex_valid_reg <= 1'b0;
            blank_reg     <= 1'b1;
            err_reg       <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            err_reg <= accept && !code_valid && !code_blank;
            if (accept && code_valid) begin
                hex_reg       <= digit;
                hex_valid_reg <= 1'b1;
                blank_reg     <= 1'b0;
                if (hex_valid_reg && !hex_ack) begin
                    overrun_reg <= 1'b1;
                end
            end else if (hex_valid_reg && hex_ack) begin
                hex_valid_reg <= 1'b0;
            end
            if (accept && code_blank) begin
                blank_reg <= 1'b1;
            end
        end
    end

    assign hex       = hex_reg;
    assign hex_valid = hex_valid_reg;
    assign blank     = blank_reg;
    assign err       = err_reg;
    assign overrun   = overrun_reg;

`ifdef SEG_DECODE_RX_ERRCNT_EN
    logic [ERRW-1:0] err_cnt_reg;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            err_cnt_reg <= '0;
        end else if (accept && !code_valid && !code_blank && (err_cnt_reg != '1)) begin
            err_cnt_reg <= err_cnt_reg + ERRW'(1);
        end
    end

    assign err_cnt = err_cnt_reg;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_seg_decode_rx.sv
module tb_seg_decode_rx;

    localparam int SC   = 4;
    localparam int ERRW = 8;

    logic            Clock = 1'b0;
    logic            Resetn = 1'b0;
    logic [6:0]      seg = 7'h7F;
    logic            hex_ack = 1'b0;
    logic [3:0]      hex;
    logic            hex_valid;
    logic            blank;
    logic            err;
    logic            overrun;
    logic [ERRW-1:0] err_cnt;

    int checks = 0;
    int errors = 0;

    seg_decode_rx #(.STABLE_CYCLES(SC), .ERRW(ERRW)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .seg       (seg),
        .hex_ack   (hex_ack),
        .hex       (hex),
        .hex_valid (hex_valid),
        .blank     (blank),
        .err       (err),
        .overrun   (overrun),
        .err_cnt   (err_cnt)
    );

    initial forever #5 Clock = ~Clock;

    // Pattern table in hex order; index is the digit value.
    logic [6:0] codes [16];
    logic [6:0] bad_codes [4];

    // Reference model: s is seg seen two edges late. The model counts how
    // many consecutive samples of s were identical. A pattern is taken
    // exactly when that run reaches SC+1 samples.
    logic [6:0] m_d1, m_s;
    int         m_run;
    logic [3:0] m_hex;
    logic       m_valid, m_blank, m_err, m_ovr;
    logic [7:0] m_errcnt;

    function automatic int classify(input logic [6:0] c);
        if (c == 7'h7F) return 16;
        for (int i = 0; i < 16; i++) if (c == codes[i]) return i;
        return 17;
    endfunction

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            m_d1 <= 7'h7F; m_s <= 7'h7F; m_run <= 1;
            m_hex <= 4'h0; m_valid <= 1'b0; m_blank <= 1'b1;
            m_err <= 1'b0; m_ovr <= 1'b0; m_errcnt <= 8'h00;
        end else begin
            automatic int  code = classify(m_s);
            automatic bit  take = (m_run == SC + 1);
            m_err <= take && (code == 17);
`ifdef SEG_DECODE_RX_ERRCNT_EN
            if (take && code == 17 && m_errcnt != 8'hFF) m_errcnt <= m_errcnt + 8'd1;
`endif
            if (take && code < 16) begin
                m_hex <= 4'(code); m_valid <= 1'b1; m_blank <= 1'b0;
                if (m_valid && !hex_ack) m_ovr <= 1'b1;
            end else if (m_valid && hex_ack) begin
                m_valid <= 1'b0;
            end
            if (take && code == 16) m_blank <= 1'b1;
            m_run <= (m_d1 == m_s) ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
            m_s   <= m_d1;
            m_d1  <= seg;
        end
    end

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic test_reset();
        Resetn = 1'b0; seg = 7'h7F; hex_ack = 1'b0;
        repeat (3) tick();
        checks++; if (hex !== 4'h0) begin errors++; $display("FAIL reset_hex got %h want 0", hex); end
        checks++; if (hex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", hex_valid); end
        checks++; if (blank !== 1'b1) begin errors++; $display("FAIL reset_blank got %b want 1", blank); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        checks++; if (err_cnt !== '0) begin errors++; $display("FAIL reset_errcnt got %h want 0", err_cnt); end
        Resetn = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    // Edge k=1 is the first edge that samples the new pattern; acceptance
    // lands on edge k = 3 + SC (edge N + 2 + SC).
    task automatic test_settle();
        seg = 7'h24;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (hex_valid !== (k >= SC + 3)) begin
                errors++; $display("FAIL settle_valid edge %0d got %b want %b", k, hex_valid, (k >= SC + 3));
            end
        end
        checks++; if (hex !== 4'h2) begin errors++; $display("FAIL settle_hex got %h want 2", hex); end
        checks++; if (blank !== 1'b0) begin errors++; $display("FAIL settle_blank got %b want 0", blank); end
        hex_ack = 1'b1; tick(); hex_ack = 1'b0;
        checks++; if (hex_valid !== 1'b0) begin errors++; $display("FAIL ack_clear got %b want 0", hex_valid); end
        $display("test_settle hex=%h", hex);
    endtask

    task automatic test_glitch();
        int seen_toggle = 0;
        int seen_hold = 0;
        hex_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            seg = (i % 2 == 0) ? 7'h24 : 7'h30;
            repeat (2) begin tick(); if (hex_valid) seen_toggle++; end
        end
        seg = 7'h30;
        repeat (10) begin tick(); if (hex_valid) seen_hold++; end
        hex_ack = 1'b0;
        checks++; if (seen_toggle !== 0) begin errors++; $display("FAIL glitch_toggle accepts got %0d want 0", seen_toggle); end
        checks++; if (seen_hold !== 1) begin errors++; $display("FAIL glitch_hold accepts got %0d want 1", seen_hold); end
        checks++; if (hex !== 4'h3) begin errors++; $display("FAIL glitch_hex got %h want 3", hex); end
        $display("test_glitch accepts=%0d hex=%h", seen_hold, hex);
    endtask

    task automatic test_blank();
        int errs_seen = 0;
        seg = 7'h12; repeat (8) tick();
        checks++; if (hex !== 4'h5) begin errors++; $display("FAIL blank_pre_hex got %h want 5", hex); end
        hex_ack = 1'b1; tick(); hex_ack = 1'b0;
        seg = 7'h7F;
        repeat (8) begin tick(); if (err) errs_seen++; end
        checks++; if (blank !== 1'b1) begin errors++; $display("FAIL blank_flag got %b want 1", blank); end
        checks++; if (hex !== 4'h5) begin errors++; $display("FAIL blank_hex got %h want 5", hex); end
        checks++; if (errs_seen !== 0) begin errors++; $display("FAIL blank_err pulses got %0d want 0", errs_seen); end
        $display("test_blank blank=%b hex=%h", blank, hex);
    endtask

    task automatic test_invalid();
        int pulses;
`ifdef SEG_DECODE_RX_ERRCNT_EN
        for (int i = 0; i < 300 && m_errcnt != 8'hFE; i++) begin
            seg = (i % 2 == 0) ? 7'h2A : 7'h7E;
            repeat (SC + 3) tick();
        end
        checks++; if (err_cnt !== 8'hFE) begin errors++; $display("FAIL errcnt_preload got %h want fe", err_cnt); end
`endif
        pulses = 0; seg = 7'h55;
        repeat (8) begin tick(); if (err) pulses++; end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL invalid_err pulses got %0d want 1", pulses); end
`ifdef SEG_DECODE_RX_ERRCNT_EN
        checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL errcnt_top got %h want ff", err_cnt); end
`else
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL errcnt_off got %h want 0", err_cnt); end
`endif
        pulses = 0; seg = 7'h2A;
        repeat (8) begin tick(); if (err) pulses++; end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL invalid_err2 pulses got %0d want 1", pulses); end
`ifdef SEG_DECODE_RX_ERRCNT_EN
        checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL errcnt_sat got %h want ff", err_cnt); end
`else
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL errcnt_off2 got %h want 0", err_cnt); end
`endif
        checks++; if (hex !== 4'h5) begin errors++; $display("FAIL invalid_hex got %h want 5", hex); end
        $display("test_invalid err_cnt=%h", err_cnt);
    endtask

    task automatic test_overrun();
        seg = 7'h79; repeat (8) tick();
        seg = 7'h78; repeat (8) tick();
        checks++; if (hex !== 4'h7) begin errors++; $display("FAIL overrun_hex got %h want 7", hex); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b want 1", overrun); end
        Resetn = 1'b0; tick(); Resetn = 1'b1;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_reset got %b want 0", overrun); end
        seg = 7'h79; repeat (8) tick();
        checks++; if (hex_valid !== 1'b1) begin errors++; $display("FAIL overrun_pre_valid got %b want 1", hex_valid); end
        seg = 7'h78;
        repeat (SC + 2) tick();
        hex_ack = 1'b1; tick(); hex_ack = 1'b0;
        checks++; if (hex !== 4'h7) begin errors++; $display("FAIL ackcoinc_hex got %h want 7", hex); end
        checks++; if (hex_valid !== 1'b1) begin errors++; $display("FAIL ackcoinc_valid got %b want 1", hex_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ackcoinc_overrun got %b want 0", overrun); end
        $display("test_overrun hex=%h overrun=%b", hex, overrun);
    endtask

    task automatic test_reset_mid();
        seg = 7'h0E; repeat (3) tick();
        Resetn = 1'b0; #1;
        checks++; if (hex !== 4'h0) begin errors++; $display("FAIL rstmid_hex got %h want 0", hex); end
        checks++; if (hex_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", hex_valid); end
        checks++; if (blank !== 1'b1) begin errors++; $display("FAIL rstmid_blank got %b want 1", blank); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rstmid_overrun got %b want 0", overrun); end
        checks++; if (err !== 1'b0 || err_cnt !== '0) begin errors++; $display("FAIL rstmid_err got %b/%h want 0/0", err, err_cnt); end
        repeat (2) tick();
        Resetn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (hex_valid !== (k >= SC + 3)) begin
                errors++; $display("FAIL rstmid_settle edge %0d got %b want %b", k, hex_valid, (k >= SC + 3));
            end
        end
        checks++; if (hex !== 4'hF) begin errors++; $display("FAIL rstmid_hex_after got %h want f", hex); end
        $display("test_reset_mid hex=%h", hex);
    endtask

    task automatic test_random();
        for (int n = 0; n < 250; n++) begin
            int r = $urandom_range(0, 9);
            int hold = $urandom_range(1, 9);
            if (r < 6) seg = codes[$urandom_range(0, 15)];
            else if (r < 8) seg = 7'h7F;
            else seg = bad_codes[$urandom_range(0, 3)];
            for (int c = 0; c < hold; c++) begin
                hex_ack = ($urandom_range(0, 3) == 0);
                tick();
                checks++; if (hex !== m_hex) begin errors++; $display("FAIL rand_hex seg %h got %h want %h", seg, hex, m_hex); end
                checks++; if (hex_valid !== m_valid) begin errors++; $display("FAIL rand_valid seg %h got %b want %b", seg, hex_valid, m_valid); end
                checks++; if (blank !== m_blank) begin errors++; $display("FAIL rand_blank seg %h got %b want %b", seg, blank, m_blank); end
                checks++; if (err !== m_err) begin errors++; $display("FAIL rand_err seg %h got %b want %b", seg, err, m_err); end
                checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL rand_overrun seg %h got %b want %b", seg, overrun, m_ovr); end
                checks++; if (err_cnt !== m_errcnt) begin errors++; $display("FAIL rand_errcnt seg %h got %h want %h", seg, err_cnt, m_errcnt); end
            end
            $display("random seg=%h hold=%0d hex=%h valid=%b", seg, hold, hex, hex_valid);
        end
        hex_ack = 1'b0;
    endtask

    initial begin
        codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        bad_codes = '{7'h55, 7'h2A, 7'h7E, 7'h01};
        @(negedge Clock);
        test_reset();
        test_settle();
        test_glitch();
        test_blank();
        test_invalid();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
